// File: rtl/mdu_ctrl.sv
// ============================================================================
// mdu_ctrl : iterative radix-2 multiply/divide sequencer for the EX stage
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module mdu_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 op_div_i,
   input  logic                 signed_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 busy_o,
   output logic                 stallreq_o
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_BYZERO = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [1:0]           state_q,  state_d;
   logic [CNT_W-1:0]     cnt_q,    cnt_d;
   logic                 op_div_q, op_div_d;
   logic                 qneg_q,   qneg_d;
   logic                 rneg_q,   rneg_d;
   logic [WIDTH-1:0]     opb_q,    opb_d;
   logic [2*WIDTH-1:0]   acc_q,    acc_d;
   logic [2*WIDTH-1:0]   result_q, result_d;

   logic                 s1, s2;
   logic [WIDTH-1:0]     mag1, mag2;
   logic                 accept;

   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_part;
   logic                 div_ge;
   logic [WIDTH-1:0]     div_sub;
   logic [2*WIDTH-1:0]   div_next;
   logic [2*WIDTH-1:0]   step_next;
   logic [WIDTH-1:0]     quo, rem;
   logic [2*WIDTH-1:0]   fixed_div, fixed_mul;

   assign s1     = opdata1_i[WIDTH-1] & signed_i;
   assign s2     = opdata2_i[WIDTH-1] & signed_i;
   assign mag1   = s1 ? -opdata1_i : opdata1_i;
   assign mag2   = s2 ? -opdata2_i : opdata2_i;
   assign accept = (state_q == S_IDLE) && start_i && !annul_i;

   // Multiply: accumulator high half gathers partial sums, low half shifts the multiplier out.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + ({1'b0, opb_q} & {(WIDTH+1){acc_q[0]}});
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: restoring step on a WIDTH+1 bit window so the shifted-out MSB is never lost.
   assign div_part = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_ge   = div_part >= {1'b0, opb_q};
   assign div_sub  = div_part[WIDTH-1:0] - opb_q;
   assign div_next = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                            : {acc_q[2*WIDTH-2:0], 1'b0};

   assign step_next = op_div_q ? div_next : mul_next;
   assign quo       = step_next[WIDTH-1:0];
   assign rem       = step_next[2*WIDTH-1:WIDTH];
   assign fixed_div = {(rneg_q ? -rem : rem), (qneg_q ? -quo : quo)};
   assign fixed_mul = qneg_q ? -step_next : step_next;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_div_d = op_div_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_div_d = op_div_i;
               qneg_d   = s1 ^ s2;
               rneg_d   = s1;
               cnt_d    = '0;
               if (op_div_i && (opdata2_i == '0)) begin
                  state_d = S_BYZERO;
                  acc_d   = {opdata1_i, {WIDTH{1'b1}}};
               end else begin
                  state_d = S_RUN;
                  if (op_div_i) begin
                     acc_d = {{WIDTH{1'b0}}, mag1};
                     opb_d = mag2;
                  end else begin
                     acc_d = {{WIDTH{1'b0}}, mag2};
                     opb_d = mag1;
                  end
               end
            end
         end
         S_RUN: begin
            if (annul_i) begin
               state_d = S_IDLE;
            end else begin
               acc_d = step_next;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  state_d  = S_DONE;
                  result_d = op_div_q ? fixed_div : fixed_mul;
               end
            end
         end
         S_BYZERO: begin
            if (annul_i) begin
               state_d = S_IDLE;
            end else begin
               state_d  = S_DONE;
               result_d = acc_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_div_q <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         opb_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_div_q <= op_div_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   // The result is registered on entry to DONE, so a late annul only hides the ready pulse.
   assign result_o   = result_q;
   assign ready_o    = (state_q == S_DONE) && !annul_i;
   assign busy_o     = (state_q != S_IDLE);
   assign stallreq_o = accept || (state_q == S_RUN) || (state_q == S_BYZERO);

endmodule

`default_nettype wire
